csp_handshake_channel: RTL and testbench

- Synchronous, synthesizable point-to-point message channel carrying WIDTH-bit tokens from one sender process to one receiver process.
- Both sides use a 4-phase bundled-data handshake: req and data go out, ack comes back, req falls, ack falls.
- An internal FIFO decouples the two sides.
- Used as the generic link between memory, memory-interface, NoC and PE blocks; default configuration carries 64-bit NoC packets.

---
 rtl/csp_channel_pkg.sv | 28 ++
 rtl/csp_fifo.sv | 70 +++++++
 rtl/csp_handshake_channel.sv | 139 +++++++++++++
 tb/tb_csp_handshake_channel.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/csp_channel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csp_channel_pkg
// Description : Shared types for the CSP handshake channel: sender/receiver FSM
//               state encodings and the NoC packet field codes used by clients.
// Revision    : 1.0 - initial release
// ============================================================================
package csp_channel_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } sendState_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_REQ  = 2'b01,
        R_WAIT = 2'b10
    } recvState_t;

    // NoC packet type field and end-of-stream marker
    localparam logic [1:0] TYPE_INPUT  = 2'b00;
    localparam logic [1:0] TYPE_KERNEL = 2'b01;
    localparam logic [1:0] TYPE_OUTPUT = 2'b11;
    localparam logic [9:0] DONE        = 10'h1FF;

endpackage
`default_nettype wire

// File: rtl/csp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : csp_fifo
// Description : Synchronous FIFO with registered occupancy; a push into a full
//               FIFO is accepted when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module csp_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wrData,
    output logic [WIDTH-1:0]           rdData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign full     = (r_count == c_CNT_FULL);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign rdData   = r_mem[r_rdPtr];
    assign w_doPop  = pop && !empty;
    assign w_doPush = push && (!full || w_doPop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= (r_wrPtr == c_PTR_LAST) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= (r_rdPtr == c_PTR_LAST) ? '0 : r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= wrData;
        end
    end

endmodule
`default_nettype wire

// File: rtl/csp_handshake_channel.sv
`default_nettype none
// ============================================================================
// Module      : csp_handshake_channel
// Description : 4-phase bundled-data point-to-point channel, sender and
//               receiver decoupled by csp_fifo. Optional counters via
//               CSP_CHANNEL_STATS_EN (xfer_cnt, stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module csp_handshake_channel
    import csp_channel_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_req,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       s_ack,
    output logic                       r_req,
    output logic [WIDTH-1:0]           r_data,
    input  logic                       r_ack,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef CSP_CHANNEL_STATS_EN
    ,
    output logic [31:0]                xfer_cnt,
    output logic [31:0]                stall_cnt
`endif
);

    sendState_t       r_sendState;
    sendState_t       w_sendNext;
    recvState_t       r_recvState;
    recvState_t       w_recvNext;
    logic             w_push;
    logic             w_pop;
    logic             w_loadData;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head;

    csp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (w_push),
        .pop    (w_pop),
        .wrData (s_data),
        .rdData (w_head),
        .full   (w_full),
        .empty  (w_empty),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sendState <= S_IDLE;
            r_recvState <= R_IDLE;
            r_data      <= '0;
        end else begin
            r_sendState <= w_sendNext;
            r_recvState <= w_recvNext;
            if (w_loadData) begin
                r_data <= w_head;
            end
        end
    end

    // Sender: one push per rising s_req; a full FIFO still accepts when the
    // receiver pops on the same edge.
    always_comb begin
        w_sendNext = r_sendState;
        w_push     = 1'b0;
        s_ack      = 1'b0;
        case (r_sendState)
            S_IDLE: begin
                if (s_req && (!w_full || w_pop)) begin
                    w_push     = 1'b1;
                    w_sendNext = S_ACK;
                end
            end
            S_ACK: begin
                s_ack = 1'b1;
                if (!s_req) begin
                    w_sendNext = S_IDLE;
                end
            end
            default: w_sendNext = S_IDLE;
        endcase
    end

    always_comb begin
        w_recvNext = r_recvState;
        w_pop      = 1'b0;
        w_loadData = 1'b0;
        r_req      = 1'b0;
        case (r_recvState)
            R_IDLE: begin
                if (!w_empty) begin
                    w_loadData = 1'b1;
                    w_recvNext = R_REQ;
                end
            end
            R_REQ: begin
                r_req = 1'b1;
                if (r_ack) begin
                    w_pop      = 1'b1;
                    w_recvNext = R_WAIT;
                end
            end
            R_WAIT: begin
                if (!r_ack) begin
                    w_recvNext = R_IDLE;
                end
            end
            default: w_recvNext = R_IDLE;
        endcase
    end

`ifdef CSP_CHANNEL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_pop) begin
                xfer_cnt <= xfer_cnt + 32'd1;
            end
            if ((r_sendState == S_IDLE) && s_req && w_full) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_csp_handshake_channel.sv
`default_nettype none
// ============================================================================
// Module      : tb_csp_handshake_channel
// Description : Self-checking bench for csp_handshake_channel (WIDTH=64,
//               DEPTH=2): per-cycle vector table plus handshake sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csp_handshake_channel;

    localparam logic [63:0] c_TOK_A  = 64'h0001_0000_0000_0019;
    localparam logic [63:0] c_TOK_AB = 64'h0000_0000_0000_00AB;
    localparam int          c_NVEC   = 28;

    typedef struct {
        logic        rst;
        logic        sReq;
        logic [63:0] sData;
        logic        rAck;
        logic        expSAck;
        logic        expRReq;
        logic [63:0] expRData;
        logic [1:0]  expCount;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sReq = 1'b0;
    logic [63:0] sData = '0;
    logic        sAck;
    logic        rReq;
    logic [63:0] rData;
    logic        rAck = 1'b0;
    logic [1:0]  count;
`ifdef CSP_CHANNEL_STATS_EN
    logic [31:0] xferCnt;
    logic [31:0] stallCnt;
`endif

    int total = 0;
    int bad   = 0;
    vec_t vecs [c_NVEC];
    logic [63:0] got [5];

    always #5 clk = ~clk;

    csp_handshake_channel #(
        .WIDTH (64),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_req     (sReq),
        .s_data    (sData),
        .s_ack     (sAck),
        .r_req     (rReq),
        .r_data    (rData),
        .r_ack     (rAck),
        .count     (count)
`ifdef CSP_CHANNEL_STATS_EN
        ,
        .xfer_cnt  (xferCnt),
        .stall_cnt (stallCnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vRst, input logic vReq, input logic [63:0] vData,
                                input logic vAck, input logic eAck, input logic eReq,
                                input logic [63:0] eData, input logic [1:0] eCnt);
        vec_t v;
        v.rst = vRst; v.sReq = vReq; v.sData = vData; v.rAck = vAck;
        v.expSAck = eAck; v.expRReq = eReq; v.expRData = eData; v.expCount = eCnt;
        return v;
    endfunction

    task automatic sendToken(input logic [63:0] d);
        int n = 0;
        sReq  = 1'b1;
        sData = d;
        do begin
            tick();
            n++;
        end while (sAck !== 1'b1 && n < 20);
        chk("send_ack", {63'd0, sAck}, 64'd1);
        sReq = 1'b0;
        tick();
    endtask

    task automatic recvToken(output logic [63:0] d);
        int n = 0;
        while (rReq !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("recv_req", {63'd0, rReq}, 64'd1);
        d    = rData;
        rAck = 1'b1;
        tick();
        chk("recv_req_drop", {63'd0, rReq}, 64'd0);
        rAck = 1'b0;
        tick();
    endtask

    initial begin
        // columns: rst sReq sData rAck | sAck rReq rData count (after the edge)
        vecs[0]  = mk(1, 0, 64'h0,    0, 0, 0, 64'h0,    2'd0);
        vecs[1]  = mk(0, 1, c_TOK_A,  0, 1, 0, 64'h0,    2'd1);
        vecs[2]  = mk(0, 1, c_TOK_A,  0, 1, 1, c_TOK_A,  2'd1);
        vecs[3]  = mk(0, 0, c_TOK_A,  0, 0, 1, c_TOK_A,  2'd1);
        vecs[4]  = mk(0, 0, 64'h0,    1, 0, 0, c_TOK_A,  2'd0);
        vecs[5]  = mk(0, 0, 64'h0,    0, 0, 0, c_TOK_A,  2'd0);
        vecs[6]  = mk(0, 1, 64'h44,   0, 1, 0, c_TOK_A,  2'd1);
        vecs[7]  = mk(0, 0, 64'h44,   0, 0, 1, 64'h44,   2'd1);
        vecs[8]  = mk(0, 1, 64'h55,   0, 1, 1, 64'h44,   2'd2);
        vecs[9]  = mk(0, 0, 64'h55,   0, 0, 1, 64'h44,   2'd2);
        vecs[10] = mk(0, 1, 64'h66,   0, 0, 1, 64'h44,   2'd2);
        vecs[11] = mk(0, 1, 64'h66,   0, 0, 1, 64'h44,   2'd2);
        vecs[12] = mk(0, 1, 64'h66,   1, 1, 0, 64'h44,   2'd2);
        vecs[13] = mk(0, 0, 64'h66,   0, 0, 0, 64'h44,   2'd2);
        vecs[14] = mk(0, 0, 64'h0,    0, 0, 1, 64'h55,   2'd2);
        vecs[15] = mk(0, 0, 64'h0,    1, 0, 0, 64'h55,   2'd1);
        vecs[16] = mk(0, 0, 64'h0,    0, 0, 0, 64'h55,   2'd1);
        vecs[17] = mk(0, 0, 64'h0,    0, 0, 1, 64'h66,   2'd1);
        vecs[18] = mk(0, 0, 64'h0,    1, 0, 0, 64'h66,   2'd0);
        vecs[19] = mk(0, 0, 64'h0,    0, 0, 0, 64'h66,   2'd0);
        vecs[20] = mk(0, 1, 64'h77,   0, 1, 0, 64'h66,   2'd1);
        vecs[21] = mk(0, 1, 64'h77,   0, 1, 1, 64'h77,   2'd1);
        vecs[22] = mk(1, 1, 64'h77,   0, 0, 0, 64'h0,    2'd0);
        vecs[23] = mk(0, 0, c_TOK_AB, 0, 0, 0, 64'h0,    2'd0);
        vecs[24] = mk(0, 1, c_TOK_AB, 0, 1, 0, 64'h0,    2'd1);
        vecs[25] = mk(0, 0, c_TOK_AB, 0, 0, 1, c_TOK_AB, 2'd1);
        vecs[26] = mk(0, 0, 64'h0,    1, 0, 0, c_TOK_AB, 2'd0);
        vecs[27] = mk(0, 0, 64'h0,    0, 0, 0, c_TOK_AB, 2'd0);

        for (int i = 0; i < c_NVEC; i++) begin
            rst   = vecs[i].rst;
            sReq  = vecs[i].sReq;
            sData = vecs[i].sData;
            rAck  = vecs[i].rAck;
            tick();
            chk($sformatf("v%0d_s_ack", i), {63'd0, sAck}, {63'd0, vecs[i].expSAck});
            chk($sformatf("v%0d_r_req", i), {63'd0, rReq}, {63'd0, vecs[i].expRReq});
            chk($sformatf("v%0d_r_data", i), rData, vecs[i].expRData);
            chk($sformatf("v%0d_count", i), {62'd0, count}, {62'd0, vecs[i].expCount});
        end

        // Back-to-back: receiver acks as soon as r_req appears
        fork
            begin
                sendToken(64'h11);
                sendToken(64'h22);
                sendToken(64'h33);
            end
            begin
                recvToken(got[0]);
                recvToken(got[1]);
                recvToken(got[2]);
            end
        join
        chk("b2b_0", got[0], 64'h11);
        chk("b2b_1", got[1], 64'h22);
        chk("b2b_2", got[2], 64'h33);
        tick();
        tick();
        chk("b2b_count", {62'd0, count}, 64'd0);
        chk("b2b_no_dup", {63'd0, rReq}, 64'd0);

        // Five tokens with exactly three full-stall cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sendToken(64'hA1);
        sendToken(64'hA2);
        sReq  = 1'b1;
        sData = 64'hA3;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d_s_ack", k), {63'd0, sAck}, 64'd0);
            chk($sformatf("stall%0d_count", k), {62'd0, count}, 64'd2);
        end
        sReq = 1'b0;
        tick();
        recvToken(got[0]);
        sendToken(64'hA3);
        recvToken(got[1]);
        sendToken(64'hA4);
        recvToken(got[2]);
        recvToken(got[3]);
        sendToken(64'hA5);
        recvToken(got[4]);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("seq5_%0d", k), got[k], 64'hA1 + 64'(k));
        end
        chk("seq5_count", {62'd0, count}, 64'd0);
`ifdef CSP_CHANNEL_STATS_EN
        chk("xfer_cnt", {32'd0, xferCnt}, 64'd5);
        chk("stall_cnt", {32'd0, stallCnt}, 64'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
